// File: rtl/frame_pkg.sv
// Shared definitions for the frame buffer swap scheduler and the SRAM address mux.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;

endpackage : frame_pkg

// File: rtl/sync_edge_detect.sv
// Rising-edge detector for a level already synchronous to clk (VSYNC/HSYNC).
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic edge_o
);

  logic level_q;

  // Previous-cycle copy of the level, updated every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign edge_o = level_i & ~level_q;

endmodule : sync_edge_detect

// File: rtl/frame_swap_sched.sv
// Commits writer/display buffer swaps only on VSYNC edges, with minimum frame pacing.
module frame_swap_sched
  import frame_pkg::*;
#(
  parameter int unsigned MIN_FRAMES = 1,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_in,
  input  logic             enable,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             swap_pending,
  output logic             buf_sel,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  localparam logic [8:0]       MIN_F   = 9'(MIN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             vs_edge;
  logic [7:0]       shown_q, shown_d;
  logic             buf_sel_q, buf_sel_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] repeat_cnt_q, repeat_cnt_d;
  logic [8:0]       pace_sum;
  logic             pace_ok;

  sync_edge_detect u_vs_edge (
    .clk_i   (clk),
    .rst_i   (reset),
    .level_i (vsync_in),
    .edge_o  (vs_edge)
  );

  assign pace_sum = {1'b0, shown_q} + {8'd0, vs_edge};
  assign pace_ok  = (pace_sum >= MIN_F);

  // Next state; an IDLE request arriving on the edge cycle is judged as PENDING would.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (swap_req && enable)
          state_d = (vs_edge && pace_ok) ? ST_COMMIT : ST_PENDING;
      end
      ST_PENDING: begin
        if (!swap_req)                         state_d = ST_IDLE;
        else if (vs_edge && pace_ok && enable) state_d = ST_COMMIT;
      end
      ST_COMMIT:   state_d = ST_WAIT_REL;
      ST_WAIT_REL: if (!swap_req) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Counters and buffer select; buf_sel flips on entry to COMMIT so it moves with swap_ack.
  always_comb begin
    buf_sel_d    = buf_sel_q;
    shown_d      = shown_q;
    frame_cnt_d  = frame_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    if (state_d == ST_COMMIT) buf_sel_d = ~buf_sel_q;
    if (state_q == ST_COMMIT)           shown_d = '0;
    else if (vs_edge && shown_q != '1)  shown_d = shown_q + 8'd1;
    if (vs_edge) frame_cnt_d = frame_cnt_q + CNT_ONE;
    if (vs_edge && state_q == ST_IDLE && !swap_req && repeat_cnt_q != '1)
      repeat_cnt_d = repeat_cnt_q + CNT_ONE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shown_q      <= '0;
      buf_sel_q    <= BUF_A;
      frame_cnt_q  <= '0;
      repeat_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shown_q      <= shown_d;
      buf_sel_q    <= buf_sel_d;
      frame_cnt_q  <= frame_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign swap_ack     = (state_q == ST_COMMIT);
  assign swap_pending = (state_q == ST_PENDING);
  assign buf_sel      = buf_sel_q;
  assign frame_cnt    = frame_cnt_q;
  assign repeat_cnt   = repeat_cnt_q;

endmodule : frame_swap_sched

// File: tb/tb_frame_swap_sched.sv
// Directed bench for frame_swap_sched: three instances (MIN_FRAMES=1, MIN_FRAMES=3, CNT_W=4).
module tb_frame_swap_sched;

  logic clk = 1'b0;
  logic reset, vsync, enable, req;

  logic        ack1, pend1, buf1;
  logic [15:0] frm1, rep1;
  logic        ack3, pend3, buf3;
  logic [15:0] frm3, rep3;
  logic        ack4, pend4, buf4;
  logic [3:0]  frm4, rep4;

  int total = 0;
  int bad   = 0;
  int ack_cnt1 = 0;
  int ack_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (ack1 === 1'b1) ack_cnt1++;

  frame_swap_sched #(.MIN_FRAMES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .vsync_in(vsync), .enable(enable), .swap_req(req),
    .swap_ack(ack1), .swap_pending(pend1), .buf_sel(buf1),
    .frame_cnt(frm1), .repeat_cnt(rep1));

  frame_swap_sched #(.MIN_FRAMES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .vsync_in(vsync), .enable(enable), .swap_req(req),
    .swap_ack(ack3), .swap_pending(pend3), .buf_sel(buf3),
    .frame_cnt(frm3), .repeat_cnt(rep3));

  frame_swap_sched #(.MIN_FRAMES(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .vsync_in(vsync), .enable(enable), .swap_req(req),
    .swap_ack(ack4), .swap_pending(pend4), .buf_sel(buf4),
    .frame_cnt(frm4), .repeat_cnt(rep4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One VSYNC frame: level high for one cycle then low for one cycle.
  task automatic pulse();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; req = 1'b0; enable = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state and idle frames
    do_reset();
    chk("rst_buf", 32'(buf1), 0);
    chk("rst_ack", 32'(ack1), 0);
    chk("rst_pend", 32'(pend1), 0);
    chk("rst_frm", 32'(frm1), 0);
    chk("rst_rep", 32'(rep1), 0);
    repeat (3) pulse();
    chk("idle_frm", 32'(frm1), 3);
    chk("idle_rep", 32'(rep1), 3);
    chk("idle_buf", 32'(buf1), 0);
    chk("idle_noack", 32'(ack_cnt1), 0);

    // Held request, commit one cycle after the edge, no double swap
    req = 1'b1; tick();
    chk("b_pend", 32'(pend1), 1);
    vsync = 1'b1; tick();
    chk("b_ack", 32'(ack1), 1);
    chk("b_buf", 32'(buf1), 1);
    chk("b_pend0", 32'(pend1), 0);
    vsync = 1'b0; tick();
    chk("b_ack_once", 32'(ack1), 0);
    repeat (10) tick();
    pulse();
    chk("b_ackcnt", 32'(ack_cnt1), 1);
    chk("b_buf_hold", 32'(buf1), 1);
    chk("b_frm", 32'(frm1), 5);
    chk("b_rep", 32'(rep1), 3);
    req = 1'b0; tick();
    pulse();
    chk("b_rep_inc", 32'(rep1), 4);
    chk("b_frm2", 32'(frm1), 6);

    // Request arriving in the same cycle as the edge
    req = 1'b1; vsync = 1'b1; tick();
    chk("c_ack", 32'(ack1), 1);
    chk("c_buf", 32'(buf1), 0);
    vsync = 1'b0; tick();
    req = 1'b0; tick();
    chk("c_rep", 32'(rep1), 4);
    chk("c_frm", 32'(frm1), 7);

    // enable low blocks the commit
    ack_base = ack_cnt1;
    req = 1'b1; tick();
    chk("d_pend", 32'(pend1), 1);
    enable = 1'b0;
    pulse(); pulse();
    chk("d_pend_hold", 32'(pend1), 1);
    chk("d_noack", 32'(ack_cnt1 - ack_base), 0);
    chk("d_buf", 32'(buf1), 0);
    enable = 1'b1;
    vsync = 1'b1; tick();
    chk("d_ack", 32'(ack1), 1);
    chk("d_buf1", 32'(buf1), 1);
    vsync = 1'b0; tick();
    req = 1'b0; tick();
    chk("d_frm", 32'(frm1), 10);

    // MIN_FRAMES=3 pacing
    do_reset();
    req = 1'b1; tick();
    pulse(); pulse();
    chk("e_pend", 32'(pend3), 1);
    chk("e_buf0", 32'(buf3), 0);
    vsync = 1'b1; tick();
    chk("e_ack", 32'(ack3), 1);
    chk("e_buf1", 32'(buf3), 1);
    vsync = 1'b0; tick();
    req = 1'b0; tick();
    req = 1'b1; tick();
    chk("e_pend2", 32'(pend3), 1);
    pulse();
    chk("e_pend_e1", 32'(pend3), 1);
    chk("e_buf_e1", 32'(buf3), 1);
    pulse();
    chk("e_pend_e2", 32'(pend3), 1);
    vsync = 1'b1; tick();
    chk("e_ack_e3", 32'(ack3), 1);
    chk("e_buf_e3", 32'(buf3), 0);
    vsync = 1'b0; tick();
    req = 1'b0; tick();

    // Reset asserted during COMMIT
    do_reset();
    pulse();
    req = 1'b1; tick();
    vsync = 1'b1; tick();
    chk("f_ack", 32'(ack1), 1);
    chk("f_buf", 32'(buf1), 1);
    chk("f_frm", 32'(frm1), 2);
    reset = 1'b1; #1;
    chk("f_rst_buf", 32'(buf1), 0);
    chk("f_rst_ack", 32'(ack1), 0);
    chk("f_rst_frm", 32'(frm1), 0);
    chk("f_rst_rep", 32'(rep1), 0);
    chk("f_rst_pend", 32'(pend1), 0);
    vsync = 1'b0; #1;
    reset = 1'b0;
    tick();
    chk("f_pend", 32'(pend1), 1);
    chk("f_buf0", 32'(buf1), 0);
    vsync = 1'b1; tick();
    chk("f_ack2", 32'(ack1), 1);
    chk("f_buf2", 32'(buf1), 1);
    vsync = 1'b0; tick();
    req = 1'b0; tick();

    // Narrow counters: repeat_cnt saturates, frame_cnt wraps
    do_reset();
    repeat (20) pulse();
    chk("g_rep_sat", 32'(rep4), 15);
    chk("g_frm_wrap", 32'(frm4), 4);
    chk("g_frm16", 32'(frm1), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_frame_swap_sched

// File: doc/frame_swap_sched.md
Name: frame_swap_sched

Overview:
- Schedules buffer-ownership swaps between the capture writer and the display reader.
- Consumes the filtered VSYNC level and commits swaps only at a frame boundary, so the display never tears.
- Enforces a minimum number of displayed frames per buffer and counts repeated frames for pacing diagnostics.
- Sits between the VSYNC filter output, the capture write engine (swap handshake) and the SRAM address muxes (buf_sel).

Parameters:
- MIN_FRAMES, 1, minimum VSYNC edges a buffer is shown before a swap may commit (legal 1..255).
- CNT_W, 16, width of frame_cnt and repeat_cnt.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- vsync_in  input  1  filtered VSYNC level, synchronous to clk
- enable  input  1  when low, no new swap is accepted; a swap already in COMMIT completes
- swap_req  input  1  writer level request: back buffer complete; held until swap_ack
- swap_ack  output  1  one-cycle pulse in the cycle buf_sel toggles
- swap_pending  output  1  request latched, waiting for a frame boundary
- buf_sel  output  1  buffer currently owned by the display; writer uses ~buf_sel
- frame_cnt  output  CNT_W  VSYNC rising edges since reset; wraps
- repeat_cnt  output  CNT_W  VSYNC edges on which no swap committed while the writer had not requested; saturates at all-ones

Behaviour:
- Reset (async, reset=1) clears the following, all 0:
  - outputs: buf_sel, swap_ack, swap_pending, frame_cnt, repeat_cnt
  - internals: vsync_q, shown_cnt
  - state: IDLE
- Frame boundary (vs_edge) = vsync_in & ~vsync_q. vsync_q registers vsync_in every cycle, in every state.
- shown_cnt (8-bit): increments on each vs_edge, saturates at 255, clears to 0 in the cycle a swap commits.
- pace_ok = (shown_cnt + vs_edge) >= MIN_FRAMES. The comparison uses a 9-bit sum.
- State IDLE:
  - swap_req & enable: go to PENDING and set swap_pending=1.
  - If vs_edge occurs in the same cycle, evaluate it as PENDING would (the request counts for this edge).
- State PENDING:
  - On vs_edge & pace_ok: go to COMMIT.
  - On vs_edge & ~pace_ok: stay in PENDING.
  - swap_req dropping before an ack is a protocol error: return to IDLE, clear swap_pending, no toggle.
- State COMMIT (exactly 1 cycle):
  - buf_sel <= ~buf_sel, swap_ack=1, swap_pending=0, shown_cnt=0.
  - Then go to WAIT_REL.
- State WAIT_REL:
  - swap_req is ignored while high.
  - Go to IDLE in the first cycle swap_req=0, so a held request never double-swaps.
- Swap latency: buf_sel toggles and swap_ack pulses in the cycle after the vs_edge cycle (1-cycle latency from the vsync_in rise seen at the clock edge).
- frame_cnt increments on every vs_edge and wraps.
- repeat_cnt increments on a vs_edge only while in IDLE with swap_req=0; it saturates.
- enable=0:
  - IDLE does not leave IDLE.
  - PENDING keeps waiting and will not commit; a commit requires enable=1 on the vs_edge cycle.
  - COMMIT and WAIT_REL proceed normally.
- Any unused state encoding goes to IDLE on the next clock.
- Reset mid-swap: all outputs take their reset values immediately. The writer must re-request after reset.

Decomposition:
- Shared package frame_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_PENDING=2'd1, ST_COMMIT=2'd2, ST_WAIT_REL=2'd3
  - the default CNT_W
  - the buffer-id constants BUF_A=1'b0, BUF_B=1'b1, also used by the SRAM address mux
- One sub-module, sync_edge_detect: holds vsync_q and produces vs_edge. It is reused by the HSYNC line counter.

Test Plan:
- Reset, then 3 vsync rises with swap_req=0 -> frame_cnt=3, repeat_cnt=3, buf_sel=0, swap_ack never high.
- MIN_FRAMES=1: swap_req=1 held, then vsync rise at cycle T -> swap_ack=1 and buf_sel=1 at T+1 only. Request held 10 more cycles plus another vsync -> no second toggle. Drop req -> IDLE, repeat_cnt increments on the next edge.
- MIN_FRAMES=3: commit at edge E, new request immediately -> swap_pending=1 across edges E+1 and E+2; toggle after edge E+3 (3 edges since the last swap).
- swap_req rises in the same cycle as the vsync edge, pacing met -> commit on that edge (ack next cycle). repeat_cnt is not incremented for that edge.
- enable=0 with req held across 2 edges -> no ack, swap_pending=1. enable=1 -> commit on the next edge.
- Assert reset during COMMIT -> buf_sel, swap_ack, frame_cnt and repeat_cnt read 0 immediately. After release with req still high -> PENDING, commit on the next edge.
- CNT_W=4: 20 edges with no request -> repeat_cnt=15 (saturated), frame_cnt=4 (wrapped).
